// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN pipeline stages: activation width and type,
// activation range limits, and the state encoding of the 2x2 max-pool FSM.
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int ACT_W = 8;

    typedef logic signed [ACT_W-1:0] act_t;

    localparam act_t ACT_MIN = act_t'(-128);
    localparam act_t ACT_MAX = act_t'(127);

    // RD0..RD3 issue the four window reads; LAST absorbs the final read data.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        RD1   = 3'd2,
        RD2   = 3'd3,
        RD3   = 3'd4,
        LAST  = 3'd5,
        WRITE = 3'd6,
        DONE  = 3'd7
    } pool_state_t;

endpackage

// File: rtl/maxpool_addr_gen.sv
// -----------------------------------------------------------------------------
// maxpool_addr_gen
// Window counters and address generation for the 2x2 / stride-2 max-pool stage.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        zero the window counters (start accepted)
//   advance      step to the next window (row-major over the output map)
//   state        current FSM state, selects the read offset within the window
//   rd_addr      conv memory address for RD0..RD3, 0 otherwise
//   wr_addr      pool memory address in WRITE, 0 otherwise
//   last_window  current window is the bottom-right one of the output map
// -----------------------------------------------------------------------------
module maxpool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IN_COLS   = 26,
    parameter int IN_ROWS   = 26,
    parameter int RD_ADDR_W = 10,
    parameter int WR_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    input  pool_state_t          state,
    output logic [RD_ADDR_W-1:0] rd_addr,
    output logic [WR_ADDR_W-1:0] wr_addr,
    output logic                 last_window
);

    // Floor division: an odd trailing column/row never forms a window.
    localparam int OUT_COLS = IN_COLS / 2;
    localparam int OUT_ROWS = IN_ROWS / 2;
    localparam int OC_W     = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int OR_W     = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    localparam logic [OC_W-1:0] LAST_COL = OC_W'(OUT_COLS - 1);
    localparam logic [OR_W-1:0] LAST_ROW = OR_W'(OUT_ROWS - 1);

    logic [OC_W-1:0] ocol;
    logic [OR_W-1:0] orow;

    // Addresses are formed at 32 bits and only then narrowed to the ports.
    logic [31:0] base;
    logic [31:0] rd_full;
    logic [31:0] wr_full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ocol <= '0;
            orow <= '0;
        end else if (advance) begin
            if (ocol == LAST_COL) begin
                ocol <= '0;
                orow <= orow + 1'b1;
            end else begin
                ocol <= ocol + 1'b1;
            end
        end
    end

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        base    = 32'(orow) * 32'(2 * IN_COLS) + 32'(ocol) * 32'd2;
        wr_full = 32'(orow) * 32'(OUT_COLS) + 32'(ocol);
        rd_full = '0;
        case (state)
            RD0:     rd_full = base;
            RD1:     rd_full = base + 32'd1;
            RD2:     rd_full = base + 32'(IN_COLS);
            RD3:     rd_full = base + 32'(IN_COLS) + 32'd1;
            default: rd_full = '0;
        endcase
    end

    assign rd_addr     = RD_ADDR_W'(rd_full);
    assign wr_addr     = (state == WRITE) ? WR_ADDR_W'(wr_full) : '0;
    assign last_window = (ocol == LAST_COL) && (orow == LAST_ROW);

endmodule

// File: rtl/maxpool_2x2.sv
// -----------------------------------------------------------------------------
// maxpool_2x2
// 2x2 / stride-2 max pooling over the signed conv result map. One full map per
// start pulse, 6 cycles per window, one write per window, done pulse at end.
//
// Optional feature: define MAXPOOL_ARGMAX_EN to add wr_idx, the RD-order index
// (0..3) of the winning element; ties resolve to the lowest index.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset (aborts a run at once)
//   start        one-cycle pulse, accepted only in IDLE
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse after the last write
//   rd_en        conv memory read enable (RD0..RD3 only)
//   rd_addr      conv memory address, row-major
//   rd_data      conv memory data, valid one cycle after rd_en
//   wr_en        pool memory write strobe
//   wr_addr      pool memory address, row-major over the output map
//   wr_data      pooled maximum
//   wr_idx       (MAXPOOL_ARGMAX_EN only) winning element index, valid with wr_en
// -----------------------------------------------------------------------------
module maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int IN_COLS   = 26,
    parameter int IN_ROWS   = 26,
    parameter int DATA_W    = ACT_W,
    parameter int RD_ADDR_W = 10,
    parameter int WR_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [RD_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 wr_en,
    output logic [WR_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]    wr_data
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [1:0]           wr_idx
`endif
);

    pool_state_t state;
    pool_state_t state_next;

    logic                     last_window;
    logic                     clear;
    logic                     advance;
    logic signed [DATA_W-1:0] rd_val;
    logic signed [DATA_W-1:0] acc;
    logic                     take;

    assign rd_val  = $signed(rd_data);
    assign clear   = (state == IDLE) && start;
    assign advance = (state == WRITE) && !last_window;
    // Strict greater-than: on a tie the earlier element is kept.
    assign take    = rd_val > acc;

    maxpool_addr_gen #(
        .IN_COLS   (IN_COLS),
        .IN_ROWS   (IN_ROWS),
        .RD_ADDR_W (RD_ADDR_W),
        .WR_ADDR_W (WR_ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .advance     (advance),
        .state       (state),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .last_window (last_window)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD0;
            RD0:     state_next = RD1;
            RD1:     state_next = RD2;
            RD2:     state_next = RD3;
            RD3:     state_next = LAST;
            LAST:    state_next = WRITE;
            WRITE:   state_next = last_window ? DONE : RD0;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data lags rd_en by one cycle, so the element read in RDn is
    // consumed while the FSM sits in the following state.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            case (state)
                RD1:              acc <= rd_val;
                RD2, RD3, LAST:   if (take) acc <= rd_val;
                default:          acc <= acc;
            endcase
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    logic [1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= 2'd0;
        end else begin
            case (state)
                RD1:     idx <= 2'd0;
                RD2:     if (take) idx <= 2'd1;
                RD3:     if (take) idx <= 2'd2;
                LAST:    if (take) idx <= 2'd3;
                default: idx <= idx;
            endcase
        end
    end
`endif

    // Output logic.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
`ifdef MAXPOOL_ARGMAX_EN
        wr_idx  = 2'd0;
`endif
        case (state)
            RD0, RD1, RD2, RD3: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            LAST: begin
                busy = 1'b1;
            end
            WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_data = acc;
`ifdef MAXPOOL_ARGMAX_EN
                wr_idx  = idx;
`endif
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
